pie_tx: RTL
===========

PIE_TX -- requirements
Module: pie_tx

Interface
REQ-001 SHALL provide parameter TARI_CYC, default 250, Tari length in CLKA cycles (12.5 us at 20 MHz).
REQ-002 SHALL provide parameter PW_CYC, default 125, low-pulse width in CLKA cycles; legal range 1 <= PW_CYC < TARI_CYC.
REQ-003 SHALL provide parameter DELIM_CYC, default 250, frame delimiter length in CLKA cycles; minimum 1.
REQ-004 SHALL provide parameter MAXLEN, default 32, maximum payload bits.
REQ-005 SHALL have port CLKA, input, 1, single system clock; all logic on the rising edge.
REQ-006 SHALL have port RSTn, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port START, input, 1, frame request, sampled on CLKA.
REQ-008 SHALL have port DATA, input, MAXLEN, payload; DATA[LEN-1] is sent first.
REQ-009 SHALL have port LEN, input, 6, payload bit count.
REQ-010 SHALL have port TX_OUT, output, 1, envelope to the carrier modulator; 1 = carrier on, 0 = carrier off.
REQ-011 SHALL have port BUSY, output, 1, frame in progress.
REQ-012 SHALL have port DONE, output, 1, one-cycle frame-complete pulse.

Function
REQ-013 SHALL implement PIE downlink encoding, the transmit end of the envelope-detected DEC_IN path.
REQ-014 SHALL use FSM states IDLE, DELIM, REF0, RTCAL, DATA, FIN.
REQ-015 In IDLE, START=1 with LEN!=0 at edge k SHALL latch DATA and min(LEN,MAXLEN) and enter DELIM; TX_OUT=0 and BUSY=1 from edge k.
REQ-016 START with LEN=0 SHALL be ignored: no state change and no DONE.
REQ-017 START while BUSY=1 SHALL be ignored; latched data SHALL NOT change mid-frame.
REQ-018 DELIM SHALL hold TX_OUT=0 for exactly DELIM_CYC cycles.
REQ-019 Every symbol SHALL consist of a high phase followed by a PW_CYC-cycle low phase.
REQ-020 REF0 (data-0 reference) SHALL be a symbol of total length TARI_CYC.
REQ-021 RTCAL SHALL be a symbol of total length 3*TARI_CYC.
REQ-022 In DATA, a 0 bit SHALL be a symbol of total length TARI_CYC; a 1 bit SHALL be a symbol of total length 2*TARI_CYC.
REQ-023 DATA SHALL send bits MSB-first and transition to FIN after the low phase of the last bit.
REQ-024 FIN SHALL last one cycle with TX_OUT=1, DONE=1 and BUSY=1, then return to IDLE with BUSY=0.
REQ-025 START asserted during the FIN cycle SHALL be ignored; the earliest accepted restart is the cycle after FIN.
REQ-026 Phase counters SHALL be wide enough for 3*TARI_CYC with no wrap-around. A phase of N cycles SHALL end exactly N cycles after it begins, with no off-by-one cycle.
REQ-027 Frame length in cycles SHALL be DELIM_CYC + 4*TARI_CYC + sum over bits of (TARI_CYC or 2*TARI_CYC), followed by 1 FIN cycle.
REQ-028 TX_OUT SHALL be driven directly from a register (glitch-free).
REQ-029 LEN > MAXLEN SHALL be clamped to MAXLEN.

Reset
REQ-030 RSTn=0 at a CLKA edge SHALL force state IDLE, TX_OUT=1, BUSY=0, DONE=0, counters 0, and latched payload 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame at the same edge with no DONE pulse; TX_OUT SHALL return to 1 immediately.
REQ-032 START SHALL be ignored while RSTn=0; the first START accepted is at the first edge after RSTn=1.

Verification
REQ-033 Defaults, DATA=0xA, LEN=4, START pulse: TX_OUT low 250 cycles; then REF0 high 125 / low 125; then RTCAL high 625 / low 125; then bits 1,0,1,0 with high phases 375/125/375/125, each followed by low 125. DONE SHALL pulse at cycle 2750 after START.
REQ-034 LEN=0 START: TX_OUT stays 1; BUSY and DONE stay 0.
REQ-035 START re-pulsed with different DATA during RTCAL: waveform unchanged; exactly one DONE.
REQ-036 RSTn=0 during the 3rd data bit: next edge TX_OUT=1, BUSY=0, no DONE. A new START after RSTn=1 SHALL produce a full, correct frame.
REQ-037 Back-to-back frames with START asserted the cycle after FIN: second delimiter begins at that edge; both frames SHALL be bit-exact.
REQ-038 LEN=40 with DATA all ones: exactly 32 one-symbols are sent (clamped to MAXLEN), then DONE.

Source files
------------

// File: rtl/pie_tx.sv
// PIE downlink encoder: delimiter, data-0 reference, RTcal, then MSB-first data
// symbols, each a high phase followed by a fixed-width low pulse.
module pie_tx #(
  parameter int TARI_CYC  = 250,
  parameter int PW_CYC    = 125,
  parameter int DELIM_CYC = 250,
  parameter int MAXLEN    = 32
) (
  input  logic              CLKA,
  input  logic              RSTn,
  input  logic              START,
  input  logic [MAXLEN-1:0] DATA,
  input  logic [5:0]        LEN,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int MAX_PHASE = (DELIM_CYC > 3 * TARI_CYC) ? DELIM_CYC : 3 * TARI_CYC;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam int IDX_W     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  // Counters are loaded with N-1 so a phase of N cycles ends exactly N edges later.
  localparam logic [CNT_W-1:0] DELIM_LD = CNT_W'(DELIM_CYC - 1);
  localparam logic [CNT_W-1:0] PW_LD    = CNT_W'(PW_CYC - 1);
  localparam logic [CNT_W-1:0] REF0_HI  = CNT_W'(TARI_CYC - PW_CYC - 1);
  localparam logic [CNT_W-1:0] RTCAL_HI = CNT_W'(3 * TARI_CYC - PW_CYC - 1);
  localparam logic [CNT_W-1:0] ZERO_HI  = CNT_W'(TARI_CYC - PW_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_HI   = CNT_W'(2 * TARI_CYC - PW_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_REF0,
    ST_RTCAL,
    ST_DATA,
    ST_FIN
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              low_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [MAXLEN-1:0] data_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [6:0]        len_clamp;
  logic [IDX_W-1:0]  first_idx;

  always_comb begin
    len_clamp = ({1'b0, LEN} > 7'(MAXLEN)) ? 7'(MAXLEN) : {1'b0, LEN};
    first_idx = IDX_W'(len_clamp - 7'd1);
  end

  function automatic logic [CNT_W-1:0] bit_high(input logic b);
    return b ? ONE_HI : ZERO_HI;
  endfunction

  always_ff @(posedge CLKA) begin
    if (!RSTn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      low_reg     <= 1'b0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (START && (LEN != 6'd0)) begin
            data_reg    <= DATA;
            bit_idx_reg <= first_idx;
            cnt_reg     <= DELIM_LD;
            low_reg     <= 1'b0;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_DELIM;
          end
        end
        ST_DELIM: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            cnt_reg   <= REF0_HI;
            tx_reg    <= 1'b1;
            state_reg <= ST_REF0;
          end
        end
        ST_REF0, ST_RTCAL, ST_DATA: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (!low_reg) begin
            low_reg <= 1'b1;
            cnt_reg <= PW_LD;
            tx_reg  <= 1'b0;
          end else begin
            // End of a symbol's low pulse: the next symbol always starts high.
            low_reg <= 1'b0;
            tx_reg  <= 1'b1;
            case (state_reg)
              ST_REF0: begin
                cnt_reg   <= RTCAL_HI;
                state_reg <= ST_RTCAL;
              end
              ST_RTCAL: begin
                cnt_reg   <= bit_high(data_reg[bit_idx_reg]);
                state_reg <= ST_DATA;
              end
              default: begin
                if (bit_idx_reg == '0) begin
                  cnt_reg   <= '0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_FIN;
                end else begin
                  bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                  cnt_reg     <= bit_high(data_reg[bit_idx_reg - IDX_W'(1)]);
                end
              end
            endcase
          end
        end
        ST_FIN: begin
          busy_reg  <= 1'b0;
          tx_reg    <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_reg;
  assign BUSY   = busy_reg;
  assign DONE   = done_reg;

endmodule
